stream_width_upsizer: RTL



---
 rtl/stream_width_upsizer.sv | 90 +++++++++
 1 files changed

// File: rtl/stream_width_upsizer.sv
// Valid/ready packer: gathers RATIO narrow beats into one registered wide word.
// RxLast closes a packet early; TxKeep marks the filled lanes from bit 0.
module stream_width_upsizer #(
  parameter int DW    = 8,
  parameter int RATIO = 4
) (
  input  logic                clki,
  input  logic                rst_n,
  input  logic                RxVld,
  input  logic [DW-1:0]       RxData,
  input  logic                RxLast,
  output logic                RxRdy,
  output logic                TxVld,
  output logic [DW*RATIO-1:0] TxData,
  output logic [RATIO-1:0]    TxKeep,
  output logic                TxLast,
  input  logic                TxRdy
);

  localparam int WW = DW * RATIO;
  localparam int IW = $clog2(RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  logic [WW-1:0]    acc_q, acc_d, merged;
  logic [RATIO-1:0] keep_q, keep_d, keep_m;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WW-1:0]    txd_q, txd_d;
  logic [RATIO-1:0] txk_q, txk_d;
  logic             txl_q, txl_d;
  logic             vld_q, vld_d;
  logic             accept, complete;

  assign RxRdy  = ~vld_q | TxRdy;
  assign TxVld  = vld_q;
  assign TxData = txd_q;
  assign TxKeep = txk_q;
  assign TxLast = txl_q;

  always_comb begin
    accept   = RxVld & RxRdy;
    complete = accept & (RxLast | (idx_q == LAST_IDX));
    merged   = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (idx_q == IW'(i)) merged[i*DW +: DW] = RxData;
    end
    keep_m = keep_q | (RATIO'(1) << idx_q);
    acc_d  = acc_q;
    keep_d = keep_q;
    idx_d  = idx_q;
    txd_d  = txd_q;
    txk_d  = txk_q;
    txl_d  = txl_q;
    vld_d  = vld_q;
    if (vld_q && TxRdy) vld_d = 1'b0;
    if (complete) begin
      txd_d  = merged;
      txk_d  = keep_m;
      txl_d  = RxLast;
      vld_d  = 1'b1;
      acc_d  = '0;
      keep_d = '0;
      idx_d  = '0;
    end else if (accept) begin
      acc_d  = merged;
      keep_d = keep_m;
      idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      keep_q <= '0;
      idx_q  <= '0;
      txd_q  <= '0;
      txk_q  <= '0;
      txl_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      keep_q <= keep_d;
      idx_q  <= idx_d;
      txd_q  <= txd_d;
      txk_q  <= txk_d;
      txl_q  <= txl_d;
      vld_q  <= vld_d;
    end
  end

endmodule
